// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku game: button count, button index map,
// default debounce length and the debouncer state encoding.
package sudoku_pkg;

  localparam int N_BTN = 11;

  localparam int BTN_START = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_LEFT  = 4;
  localparam int BTN_X     = 5;
  localparam int BTN_Y     = 6;
  localparam int BTN_Z     = 7;
  localparam int BTN_V     = 8;
  localparam int BTN_R     = 9;
  localparam int BTN_O     = 10;

  // 5 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

  // Isolates the lowest set bit; lower index wins arbitration.
  function automatic logic [N_BTN-1:0] lowest_set(input logic [N_BTN-1:0] v);
    return v & (~v + N_BTN'(1));
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button pins in, per-command press pulses and debounced levels out.
interface button_conditioner_if;
  import sudoku_pkg::*;

  logic [N_BTN-1:0] btn_raw;
  logic             start, up, right, down, left;
  logic             x, y, z, v, r, o;
  logic [N_BTN-1:0] btn_level;
  logic             collision;

  // Board / stimulus side
  modport master (
    output btn_raw,
    input  start, up, right, down, left, x, y, z, v, r, o,
    input  btn_level, collision
  );

  // Conditioner side
  modport slave (
    input  btn_raw,
    output start, up, right, down, left, x, y, z, v, r, o,
    output btn_level, collision
  );
endinterface

// File: rtl/btn_debounce.sv
// One-bit synchroniser plus debouncer. The synchronised level must disagree
// with the accepted level on DEBOUNCE_CYCLES+1 consecutive edges before the
// accepted level flips; rise_o flags the edge at which it will flip 0->1.
module btn_debounce
  import sudoku_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic pressed_i,
  output logic level_o,
  output logic rise_o
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             accept;

  // Two-flop synchroniser, cleared to the released value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pressed_i;
      sync2_q <= sync1_q;
    end
  end

  // Mismatch has persisted long enough; the counter tops out here, never wraps
  assign accept = (state_q == DB_COUNTING) && (sync2_q != level_q) && (cnt_q == CNT_MAX);

  // Debounce FSM: STABLE while sync agrees, COUNTING while it disagrees
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      case (state_q)
        DB_STABLE: begin
          if (sync2_q != level_q) begin
            state_q <= DB_COUNTING;
            cnt_q   <= CNT_W'(1);
          end
        end
        DB_COUNTING: begin
          if (sync2_q == level_q) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else if (accept) begin
            level_q <= ~level_q;
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= DB_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = accept & ~level_q;

endmodule

// File: rtl/button_conditioner.sv
// Button front end for the game FSM: normalises polarity, debounces every
// button and turns accepted presses into single-cycle command pulses, letting
// only the lowest-index press through when several land in the same cycle.
module button_conditioner
  import sudoku_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW_BTN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] pressed;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pulse_d, pulse_q;
  logic             collision_d, collision_q;

  // 1 = pressed, whatever the board polarity
  assign pressed = bus.btn_raw ^ {N_BTN{ACTIVE_LOW_BTN}};

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk       (clk),
      .reset     (reset),
      .pressed_i (pressed[i]),
      .level_o   (level[i]),
      .rise_o    (rise[i])
    );
  end

  // Losers of arbitration are dropped for good; they only show in collision
  assign pulse_d     = lowest_set(rise);
  assign collision_d = |(rise & ~pulse_d);

  // Pulses register on the same edge the debounced level rises
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      pulse_q     <= pulse_d;
      collision_q <= collision_d;
    end
  end

  assign bus.start     = pulse_q[BTN_START];
  assign bus.up        = pulse_q[BTN_UP];
  assign bus.right     = pulse_q[BTN_RIGHT];
  assign bus.down      = pulse_q[BTN_DOWN];
  assign bus.left      = pulse_q[BTN_LEFT];
  assign bus.x         = pulse_q[BTN_X];
  assign bus.y         = pulse_q[BTN_Y];
  assign bus.z         = pulse_q[BTN_Z];
  assign bus.v         = pulse_q[BTN_V];
  assign bus.r         = pulse_q[BTN_R];
  assign bus.o         = pulse_q[BTN_O];
  assign bus.btn_level = level;
  assign bus.collision = collision_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-high instance and an active-low
// instance, both with a 4-cycle debounce. Expected pulses are queued when a
// stimulus is applied and matched by a per-instance monitor.
module tb_button_conditioner;
  import sudoku_pkg::*;

  typedef struct {
    int               cyc;
    logic [N_BTN-1:0] pulse;
    logic             col;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  button_conditioner_if if0 ();
  button_conditioner_if if1 ();

  button_conditioner #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW_BTN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  button_conditioner #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW_BTN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N_BTN-1:0] obs0, obs1;
  assign obs0 = {if0.o, if0.r, if0.v, if0.z, if0.y, if0.x, if0.left, if0.down, if0.right, if0.up, if0.start};
  assign obs1 = {if1.o, if1.r, if1.v, if1.z, if1.y, if1.x, if1.left, if1.down, if1.right, if1.up, if1.start};

  function automatic logic [N_BTN-1:0] onehot(input int i);
    logic [N_BTN-1:0] b;
    b = '0;
    b[i] = 1'b1;
    return b;
  endfunction

  // Scoreboard monitor, active-high instance
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if ($countones(obs0) > 1) begin
      failures++;
      $display("FAIL onehot_dut0 cyc=%0d pulses=%b want at most one", cyc, obs0);
    end
    if (obs0 != '0 || if0.collision) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL unexpected_dut0 cyc=%0d pulses=%b col=%b want none", cyc, obs0, if0.collision);
      end else begin
        e = q0.pop_front();
        if (cyc !== e.cyc || obs0 !== e.pulse || if0.collision !== e.col) begin
          failures++;
          $display("FAIL pulse_dut0 got cyc=%0d pulses=%b col=%b want cyc=%0d pulses=%b col=%b",
                   cyc, obs0, if0.collision, e.cyc, e.pulse, e.col);
        end
      end
    end
  end

  // Scoreboard monitor, active-low instance
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if ($countones(obs1) > 1) begin
      failures++;
      $display("FAIL onehot_dut1 cyc=%0d pulses=%b want at most one", cyc, obs1);
    end
    if (obs1 != '0 || if1.collision) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL unexpected_dut1 cyc=%0d pulses=%b col=%b want none", cyc, obs1, if1.collision);
      end else begin
        e = q1.pop_front();
        if (cyc !== e.cyc || obs1 !== e.pulse || if1.collision !== e.col) begin
          failures++;
          $display("FAIL pulse_dut1 got cyc=%0d pulses=%b col=%b want cyc=%0d pulses=%b col=%b",
                   cyc, obs1, if1.collision, e.cyc, e.pulse, e.col);
        end
      end
    end
  end

  task automatic test_reset();
    #3;
    checks++;
    if (obs0 !== '0 || if0.btn_level !== '0 || if0.collision !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut0 pulses=%b level=%b col=%b want all 0", obs0, if0.btn_level, if0.collision);
    end
    checks++;
    if (obs1 !== '0 || if1.btn_level !== '0 || if1.collision !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut1 pulses=%b level=%b col=%b want all 0", obs1, if1.btn_level, if1.collision);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (if0.btn_level !== '0 || if1.btn_level !== '0) begin
      failures++;
      $display("FAIL idle_level got %b/%b want 0/0", if0.btn_level, if1.btn_level);
    end
  endtask

  task automatic test_clean_press();
    int k, rr;
    @(negedge clk);
    if0.btn_raw[BTN_UP] = 1'b1;
    k = cyc + 1;
    q0.push_back('{k + 6, onehot(BTN_UP), 1'b0});
    while (cyc < k + 5) @(negedge clk);
    checks++;
    if (if0.btn_level[BTN_UP] !== 1'b0) begin
      failures++;
      $display("FAIL press_level_early got %b want 0", if0.btn_level[BTN_UP]);
    end
    @(negedge clk);
    checks++;
    if (if0.btn_level[BTN_UP] !== 1'b1) begin
      failures++;
      $display("FAIL press_level_rise got %b want 1", if0.btn_level[BTN_UP]);
    end
    while (cyc < k + 9) @(negedge clk);
    if0.btn_raw[BTN_UP] = 1'b0;
    rr = cyc + 1;
    while (cyc < rr + 5) @(negedge clk);
    checks++;
    if (if0.btn_level[BTN_UP] !== 1'b1) begin
      failures++;
      $display("FAIL release_level_early got %b want 1", if0.btn_level[BTN_UP]);
    end
    @(negedge clk);
    checks++;
    if (if0.btn_level[BTN_UP] !== 1'b0) begin
      failures++;
      $display("FAIL release_level_fall got %b want 0", if0.btn_level[BTN_UP]);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL clean_drain got %0d pending want 0", q0.size());
      q0.delete();
    end
  endtask

  task automatic test_bounce();
    int k;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if0.btn_raw[BTN_X] = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    checks++;
    if (if0.btn_level[BTN_X] !== 1'b0) begin
      failures++;
      $display("FAIL bounce_level got %b want 0", if0.btn_level[BTN_X]);
    end
    if0.btn_raw[BTN_X] = 1'b1;
    k = cyc + 1;
    q0.push_back('{k + 6, onehot(BTN_X), 1'b0});
    while (cyc < k + 8) @(negedge clk);
    checks++;
    if (if0.btn_level[BTN_X] !== 1'b1) begin
      failures++;
      $display("FAIL bounce_settled got %b want 1", if0.btn_level[BTN_X]);
    end
    if0.btn_raw[BTN_X] = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL bounce_drain got %0d pending want 0", q0.size());
      q0.delete();
    end
  endtask

  task automatic test_simultaneous();
    int k;
    @(negedge clk);
    if0.btn_raw[BTN_X] = 1'b1;
    if0.btn_raw[BTN_Z] = 1'b1;
    k = cyc + 1;
    q0.push_back('{k + 6, onehot(BTN_X), 1'b1});
    while (cyc < k + 8) @(negedge clk);
    checks++;
    if (if0.btn_level[BTN_X] !== 1'b1 || if0.btn_level[BTN_Z] !== 1'b1) begin
      failures++;
      $display("FAIL simul_level got x=%b z=%b want 1/1", if0.btn_level[BTN_X], if0.btn_level[BTN_Z]);
    end
    repeat (6) @(negedge clk);
    if0.btn_raw[BTN_X] = 1'b0;
    if0.btn_raw[BTN_Z] = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL simul_drain got %0d pending want 0", q0.size());
      q0.delete();
    end
  endtask

  task automatic test_staggered();
    int k1, k2;
    @(negedge clk);
    if0.btn_raw[BTN_X] = 1'b1;
    k1 = cyc + 1;
    repeat (3) @(negedge clk);
    if0.btn_raw[BTN_Z] = 1'b1;
    k2 = cyc + 1;
    q0.push_back('{k1 + 6, onehot(BTN_X), 1'b0});
    q0.push_back('{k2 + 6, onehot(BTN_Z), 1'b0});
    while (cyc < k2 + 8) @(negedge clk);
    if0.btn_raw[BTN_X] = 1'b0;
    if0.btn_raw[BTN_Z] = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL stagger_drain got %0d pending want 0", q0.size());
      q0.delete();
    end
  endtask

  task automatic test_reset_async();
    int k, m;
    // A settled level must vanish as soon as reset is asserted
    @(negedge clk);
    if0.btn_raw[BTN_RIGHT] = 1'b1;
    k = cyc + 1;
    q0.push_back('{k + 6, onehot(BTN_RIGHT), 1'b0});
    while (cyc < k + 8) @(negedge clk);
    checks++;
    if (if0.btn_level[BTN_RIGHT] !== 1'b1) begin
      failures++;
      $display("FAIL async_pre_level got %b want 1", if0.btn_level[BTN_RIGHT]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (if0.btn_level !== '0 || obs0 !== '0 || if0.collision !== 1'b0) begin
      failures++;
      $display("FAIL async_clear got level=%b pulses=%b col=%b want 0", if0.btn_level, obs0, if0.collision);
    end
    if0.btn_raw[BTN_RIGHT] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    // Reset lands mid-debounce with start held across it
    if0.btn_raw[BTN_START] = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (if0.btn_level !== '0 || obs0 !== '0 || if0.collision !== 1'b0) begin
      failures++;
      $display("FAIL middeb_clear got level=%b pulses=%b col=%b want 0", if0.btn_level, obs0, if0.collision);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m = cyc;
    q0.push_back('{m + 7, onehot(BTN_START), 1'b0});
    while (cyc < m + 9) @(negedge clk);
    checks++;
    if (if0.btn_level[BTN_START] !== 1'b1) begin
      failures++;
      $display("FAIL held_reset_level got %b want 1", if0.btn_level[BTN_START]);
    end
    if0.btn_raw[BTN_START] = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL reset_drain got %0d pending want 0", q0.size());
      q0.delete();
    end
  endtask

  task automatic test_active_low();
    int k;
    @(negedge clk);
    checks++;
    if (if1.btn_level !== '0) begin
      failures++;
      $display("FAIL actlow_idle got %b want 0", if1.btn_level);
    end
    if1.btn_raw[BTN_LEFT] = 1'b0;
    k = cyc + 1;
    q1.push_back('{k + 6, onehot(BTN_LEFT), 1'b0});
    while (cyc < k + 8) @(negedge clk);
    checks++;
    if (if1.btn_level !== onehot(BTN_LEFT)) begin
      failures++;
      $display("FAIL actlow_level got %b want %b", if1.btn_level, onehot(BTN_LEFT));
    end
    if1.btn_raw[BTN_LEFT] = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL actlow_drain got %0d pending want 0", q1.size());
      q1.delete();
    end
  endtask

  initial begin
    reset = 1'b0;
    if0.btn_raw = '0;
    if1.btn_raw = '1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_staggered();
    test_reset_async();
    test_active_low();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d want completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
